ringoscillator_tap_controller: RTL and testbench

//  Control and measurement end for ringoscillator_adjustable: accepts tap-change requests, drives osc_tap/osc_rst

---
 rtl/ringoscillator_tap_controller_pkg.sv | 32 +++
 rtl/ringoscillator_edge_sync.sv | 29 ++
 rtl/ringoscillator_tap_controller.sv | 158 +++++++++++++++
 tb/tb_ringoscillator_tap_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringoscillator_tap_controller_pkg.sv
// Shared definitions for the ring-oscillator tap controller: FSM state encoding,
// tap-width derivation (identical to the oscillator's) and a small helper.
// Latency: n/a (package). Backpressure: n/a.
`ifndef RINGOSCILLATOR_TAP_CONTROLLER_PKG_SV
`define RINGOSCILLATOR_TAP_CONTROLLER_PKG_SV
package ringoscillator_tap_controller_pkg;

   localparam logic [1:0] ENC_IDLE       = 2'd0;
   localparam logic [1:0] ENC_RESET_HOLD = 2'd1;
   localparam logic [1:0] ENC_SETTLE     = 2'd2;
   localparam logic [1:0] ENC_MEASURE    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE       = ENC_IDLE,
      ST_RESET_HOLD = ENC_RESET_HOLD,
      ST_SETTLE     = ENC_SETTLE,
      ST_MEASURE    = ENC_MEASURE
   } state_t;

   // Must match the oscillator's tap select width exactly.
   function automatic int tap_width(input int max_taps);
      return $clog2(max_taps - 1) + 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`endif

// File: rtl/ringoscillator_edge_sync.sv
// Purpose: 2-FF synchronizer for the asynchronous oscillator output plus one delay FF for rising-edge detect.
// Latency: rise_pulse asserts 2-3 clk after a rising edge on async_in. Backpressure: none (free-running).
// Ports: clk, rst (sync, active-high), async_in (asynchronous), rise_pulse (one-cycle pulse per rising edge).
module ringoscillator_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pulse
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/ringoscillator_tap_controller.sv
// Purpose: tap-change control and edge-count measurement for an adjustable ring oscillator.
// Latency: accept at N -> osc_rst high N+1..N+RST, measuring from N+1+RST+SETTLE, meas_valid every GATE clks.
// Backpressure: req_ready only in IDLE/MEASURE; a request in MEASURE aborts the running window.
// Ports: clk, rst (sync active-high); req_valid/req_tap/req_ready (host request);
//        osc_tap/osc_rst/osc_in (oscillator side); meas_valid/meas_count/meas_overflow (result); busy.
module ringoscillator_tap_controller
   import ringoscillator_tap_controller_pkg::*;
#(
   parameter  int MAX_TAPS      = 4,
   parameter  int RST_CYCLES    = 4,
   parameter  int SETTLE_CYCLES = 16,
   parameter  int GATE_CYCLES   = 1000,
   parameter  int COUNT_WIDTH   = 16,
   localparam int TAPWIDTH      = tap_width(MAX_TAPS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic [TAPWIDTH-1:0]    req_tap,
   output logic                   req_ready,
   output logic [TAPWIDTH-1:0]    osc_tap,
   output logic                   osc_rst,
   input  logic                   osc_in,
   output logic                   meas_valid,
   output logic [COUNT_WIDTH-1:0] meas_count,
   output logic                   meas_overflow,
   output logic                   busy
);

   // One phase counter is shared by all timed states, so it is sized for the longest of them.
   localparam int PH_MAX = max3(RST_CYCLES, SETTLE_CYCLES, GATE_CYCLES);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PH_W-1:0]        RST_LAST    = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0]        SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]        GATE_LAST   = PH_W'(GATE_CYCLES - 1);
   localparam logic [TAPWIDTH-1:0]    TAP_LAST    = TAPWIDTH'(MAX_TAPS - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = {COUNT_WIDTH{1'b1}};

   state_t                 state;
   state_t                 state_nxt;
   logic [PH_W-1:0]        phase;
   logic [PH_W-1:0]        phase_nxt;
   logic                   accept;
   logic                   win_start;
   logic                   win_end;
   logic                   rise_pulse;
   logic [COUNT_WIDTH-1:0] edge_cnt;
   logic                   edge_ovf;
   logic [TAPWIDTH-1:0]    tap_clamped;

   ringoscillator_edge_sync u_edge_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (osc_in),
      .rise_pulse (rise_pulse)
   );

   assign tap_clamped = (req_tap > TAP_LAST) ? TAP_LAST : req_tap;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         phase <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      phase_nxt = phase + 1'b1;
      win_start = 1'b0;
      win_end   = 1'b0;
      req_ready = 1'b0;
      osc_rst   = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            osc_rst   = 1'b1;
            phase_nxt = '0;
         end
         ST_RESET_HOLD: begin
            osc_rst = 1'b1;
            busy    = 1'b1;
            if (phase == RST_LAST) begin
               state_nxt = ST_SETTLE;
               phase_nxt = '0;
            end
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (phase == SETTLE_LAST) begin
               state_nxt = ST_MEASURE;
               phase_nxt = '0;
               win_start = 1'b1;
            end
         end
         ST_MEASURE: begin
            req_ready = 1'b1;
            if (phase == GATE_LAST) begin
               phase_nxt = '0;
               win_end   = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
         end
      endcase
      accept = req_valid & req_ready;
      // A request always wins, including on the last window cycle: the window is dropped.
      if (accept) begin
         state_nxt = ST_RESET_HOLD;
         phase_nxt = '0;
         win_start = 1'b0;
         win_end   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         osc_tap       <= '0;
         edge_cnt      <= '0;
         edge_ovf      <= 1'b0;
         meas_valid    <= 1'b0;
         meas_count    <= '0;
         meas_overflow <= 1'b0;
      end else begin
         meas_valid <= win_end;
         // osc_tap only moves on accept, which always enters RESET_HOLD, so the oscillator is held in reset.
         if (accept) begin
            osc_tap <= tap_clamped;
         end
         if (win_end) begin
            meas_count    <= edge_cnt;
            meas_overflow <= edge_ovf;
         end
         if (win_start) begin
            edge_cnt <= '0;
            edge_ovf <= 1'b0;
         end else if (win_end) begin
            // An edge seen on the boundary cycle belongs to the window that is starting.
            edge_cnt <= COUNT_WIDTH'(rise_pulse);
            edge_ovf <= 1'b0;
         end else if (state == ST_MEASURE && rise_pulse) begin
            if (edge_cnt == CNT_MAX) begin
               edge_ovf <= 1'b1;
            end else begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ringoscillator_tap_controller.sv
// Purpose: self-checking bench for ringoscillator_tap_controller with behavioural oscillator models.
// Latency: n/a. Backpressure: n/a.
// Three instances: defaults (A), COUNT_WIDTH=4 (B), MAX_TAPS=3 (C).
module tb_ringoscillator_tap_controller;
   import ringoscillator_tap_controller_pkg::*;

   localparam int TW_A = tap_width(4);
   localparam int TW_C = tap_width(3);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- DUT A: defaults ----------------
   logic            rst_a = 1'b1, req_valid_a = 1'b0, req_ready_a, osc_rst_a, meas_valid_a;
   logic            meas_overflow_a, busy_a;
   logic            osc_in_a = 1'b0;
   logic [TW_A-1:0] req_tap_a = '0, osc_tap_a;
   logic [15:0]     meas_count_a;

   ringoscillator_tap_controller dut_a (
      .clk(clk), .rst(rst_a), .req_valid(req_valid_a), .req_tap(req_tap_a), .req_ready(req_ready_a),
      .osc_tap(osc_tap_a), .osc_rst(osc_rst_a), .osc_in(osc_in_a), .meas_valid(meas_valid_a),
      .meas_count(meas_count_a), .meas_overflow(meas_overflow_a), .busy(busy_a)
   );

   // Oscillator period (clk cycles) per tap; stops while osc_rst is high.
   int tap_per_a [8] = '{20, 40, 10, 8, 8, 8, 8, 8};
   int oc_a = 0;
   always @(negedge clk) begin
      if (osc_rst_a !== 1'b0) begin
         oc_a     <= 0;
         osc_in_a <= 1'b0;
      end else begin
         osc_in_a <= (oc_a < tap_per_a[osc_tap_a] / 2);
         oc_a     <= (oc_a + 1 >= tap_per_a[osc_tap_a]) ? 0 : oc_a + 1;
      end
   end

   // osc_tap may only change while the oscillator is held in reset.
   logic            mon_en = 1'b0;
   logic [TW_A-1:0] prev_tap_a = '0;
   always @(posedge clk) begin
      #1;
      if (mon_en && osc_tap_a !== prev_tap_a) chk("a_tap_change_under_rst", 32'(osc_rst_a), 32'd1);
      prev_tap_a = osc_tap_a;
   end

   // ---------------- DUT B: COUNT_WIDTH=4 ----------------
   logic            rst_b = 1'b1, req_valid_b = 1'b0, req_ready_b, osc_rst_b, meas_valid_b;
   logic            meas_overflow_b, busy_b;
   logic            osc_in_b = 1'b0;
   logic [TW_A-1:0] req_tap_b = '0, osc_tap_b;
   logic [3:0]      meas_count_b;

   ringoscillator_tap_controller #(.COUNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_tap(req_tap_b), .req_ready(req_ready_b),
      .osc_tap(osc_tap_b), .osc_rst(osc_rst_b), .osc_in(osc_in_b), .meas_valid(meas_valid_b),
      .meas_count(meas_count_b), .meas_overflow(meas_overflow_b), .busy(busy_b)
   );

   int per_b = 4;
   int oc_b  = 0;
   always @(negedge clk) begin
      if (osc_rst_b !== 1'b0) begin
         oc_b     <= 0;
         osc_in_b <= 1'b0;
      end else begin
         osc_in_b <= (oc_b < per_b / 2);
         oc_b     <= (oc_b + 1 >= per_b) ? 0 : oc_b + 1;
      end
   end

   // ---------------- DUT C: MAX_TAPS=3 ----------------
   logic            rst_c = 1'b1, req_valid_c = 1'b0, req_ready_c, osc_rst_c, meas_valid_c;
   logic            meas_overflow_c, busy_c;
   logic            osc_in_c = 1'b0;
   logic [TW_C-1:0] req_tap_c = '0, osc_tap_c;
   logic [15:0]     meas_count_c;

   ringoscillator_tap_controller #(.MAX_TAPS(3)) dut_c (
      .clk(clk), .rst(rst_c), .req_valid(req_valid_c), .req_tap(req_tap_c), .req_ready(req_ready_c),
      .osc_tap(osc_tap_c), .osc_rst(osc_rst_c), .osc_in(osc_in_c), .meas_valid(meas_valid_c),
      .meas_count(meas_count_c), .meas_overflow(meas_overflow_c), .busy(busy_c)
   );

   // ---------------- helpers ----------------
   task automatic wait_mv_a(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         if (meas_valid_a === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_mv_b(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         step();
         if (meas_valid_b === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic chk_reset_a(input string name);
      chk(name, 32'({osc_rst_a, osc_tap_a, req_ready_a, meas_valid_a, meas_count_a, meas_overflow_a, busy_a}),
          32'({1'b1, 3'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0}));
   endtask

   // Accept a request on DUT A in the current cycle (N) and follow it through two measurement windows.
   // Returns on the cycle of the second meas_valid, i.e. the first cycle of a fresh window.
   task automatic do_req_a(input logic [TW_A-1:0] tap, input logic [TW_A-1:0] exp_tap, input int exp_cnt);
      int n;
      int bad;
      req_valid_a = 1'b1;
      req_tap_a   = tap;
      chk("a_req_ready_before_accept", 32'(req_ready_a), 32'd1);
      step();                                   // cycle N+1
      req_valid_a = 1'b0;
      chk("a_osc_tap_after_accept", 32'(osc_tap_a), 32'(exp_tap));
      bad = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) step();
         if (osc_rst_a !== (i <= 4) || busy_a !== 1'b1 || req_ready_a !== 1'b0 || meas_valid_a !== 1'b0)
            if (bad == 0) bad = i;
      end
      chk("a_hold_settle_first_bad_cycle", 32'(bad), 32'd0);
      step();                                   // cycle N+21: MEASURE
      chk("a_measure_entry_rst_busy_ready", 32'({osc_rst_a, busy_a, req_ready_a}), 32'(3'b001));
      wait_mv_a(1100, n);
      chk("a_first_valid_latency", 32'(n), 32'd1000);
      chk_rng("a_first_count", int'(meas_count_a), exp_cnt - 1, exp_cnt);
      chk("a_first_overflow", 32'(meas_overflow_a), 32'd0);
      step();
      chk("a_valid_one_cycle", 32'(meas_valid_a), 32'd0);
      wait_mv_a(1100, n);
      chk("a_window_period", 32'(n), 32'd999);
      chk("a_steady_count", 32'(meas_count_a), 32'(exp_cnt));
      chk("a_steady_overflow", 32'(meas_overflow_a), 32'd0);
   endtask

   typedef struct {
      logic [TW_A-1:0] tap;
      logic [TW_A-1:0] exp_tap;
      int              exp_cnt;
   } vec_a_t;

   typedef struct {
      logic [TW_C-1:0] tap;
      logic [TW_C-1:0] exp_tap;
   } vec_c_t;

   vec_a_t tab_a [4];
   vec_c_t tab_c [3];

   initial begin
      int n;
      int bad;

      // Tap -> period: 0:20, 1:40, 2:10, 3:8 clks; 1000-clk window gives 1000/period edges.
      tab_a[0] = '{3'd2, 3'd2, 100};
      tab_a[1] = '{3'd0, 3'd0, 50};
      tab_a[2] = '{3'd6, 3'd3, 125};   // out of range, clamps to top tap
      tab_a[3] = '{3'd1, 3'd1, 25};
      tab_c[0] = '{2'd3, 2'd2};        // clamped
      tab_c[1] = '{2'd1, 2'd1};
      tab_c[2] = '{2'd2, 2'd2};

      // --- reset with a request present: request ignored ---
      rst_a       = 1'b1;
      req_valid_a = 1'b1;
      req_tap_a   = 3'd2;
      step();
      step();
      chk_reset_a("a_reset_state");
      rst_a       = 1'b0;
      req_valid_a = 1'b0;
      mon_en      = 1'b1;
      bad = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (osc_rst_a !== 1'b1 || osc_tap_a !== 3'd0 || req_ready_a !== 1'b1 || meas_valid_a !== 1'b0 ||
             busy_a !== 1'b0)
            if (bad == 0) bad = i;
      end
      chk("a_idle_20_first_bad_cycle", 32'(bad), 32'd0);

      // --- table: tap changes, from IDLE first then from MEASURE ---
      for (int k = 0; k < 4; k++) do_req_a(tab_a[k].tap, tab_a[k].exp_tap, tab_a[k].exp_cnt);

      // --- abort mid-window, then abort on the last window cycle ---
      for (int i = 0; i < 500; i++) step();
      do_req_a(3'd1, 3'd1, 25);
      for (int i = 0; i < 999; i++) step();    // now on the last cycle of the running window
      do_req_a(3'd3, 3'd3, 125);

      // --- rst in MEASURE, then in SETTLE ---
      for (int i = 0; i < 100; i++) step();
      rst_a = 1'b1;
      step();
      chk_reset_a("a_rst_in_measure");
      rst_a       = 1'b0;
      req_valid_a = 1'b1;
      req_tap_a   = 3'd2;
      step();
      req_valid_a = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("a_in_settle_before_rst", 32'({osc_rst_a, busy_a}), 32'(2'b01));
      rst_a = 1'b1;
      step();
      chk_reset_a("a_rst_in_settle");
      rst_a = 1'b0;
      wait_mv_a(1100, n);
      chk("a_no_valid_after_rst", 32'(n), 32'hFFFF_FFFF);
      chk("a_idle_after_rst", 32'({osc_rst_a, req_ready_a, busy_a}), 32'(3'b110));

      // --- DUT B: saturation, then recovery ---
      rst_a = 1'b1;
      rst_b = 1'b1;
      step();
      step();
      chk("b_reset_rst_busy_ready_valid", 32'({osc_rst_b, busy_b, req_ready_b, meas_valid_b}), 32'(4'b1010));
      rst_b       = 1'b0;
      per_b       = 4;
      req_valid_b = 1'b1;
      req_tap_b   = 3'd0;
      step();
      req_valid_b = 1'b0;
      wait_mv_b(1100, n);
      chk("b_first_valid_latency", 32'(n), 32'd1020);
      chk("b_saturated_count", 32'(meas_count_b), 32'd15);
      chk("b_saturated_overflow", 32'(meas_overflow_b), 32'd1);
      per_b = 100;
      wait_mv_b(1100, n);
      chk("b_second_latency", 32'(n), 32'd1000);
      chk("b_second_overflow", 32'(meas_overflow_b), 32'd0);
      wait_mv_b(1100, n);
      chk("b_third_latency", 32'(n), 32'd1000);
      chk("b_recovered_count", 32'(meas_count_b), 32'd10);
      chk("b_recovered_overflow", 32'(meas_overflow_b), 32'd0);

      // --- DUT C: tap clamp with MAX_TAPS=3 ---
      rst_b = 1'b1;
      rst_c = 1'b1;
      step();
      step();
      rst_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = -1;
         for (int i = 0; i < 100; i++) begin
            if (req_ready_c === 1'b1) begin
               n = i;
               break;
            end
            step();
         end
         chk_rng("c_ready_wait", n, 0, 99);
         req_valid_c = 1'b1;
         req_tap_c   = tab_c[k].tap;
         step();
         req_valid_c = 1'b0;
         chk("c_osc_tap_and_rst", 32'({osc_tap_c, osc_rst_c}), 32'({tab_c[k].exp_tap, 1'b1}));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
